switch_alu_seq: RTL
===================

// Module: switch_alu_seq
// PURPOSE
//  Parametrised operand-sequencing ALU for the switch/button console. Replaces the fixed 4-bit ADD/SUB/MUL/ST/LD/CMP/NAND/NOR/XOR engine.
//  Collects an opcode, then one or two operands, on successive rising edges of the "done" button.
//  Executes signed arithmetic, compare and logic ops, and holds a small register file for ST/LD.
//  Feeds the bin2bcd / 7-segment display path; that path consumes result, cmp_flags and err.
// PARAMETERS
//  WIDTH   4   operand width in bits (signed two's complement), 2..16
//  NREG    8   register-file depth, power of two, 2..16
//  RAW     3   register address width, equal to log2(NREG)
// PORTS
//  clk         in   1         system clock
//  reset       in   1         synchronous, active-low reset
//  done        in   1         step button, level input, already synchronised/debounced; internally edge-detected
//  op_in       in   4         opcode, sampled in IDLE on a done edge
//  data_in     in   WIDTH     operand / address / store value, sampled on a done edge
//  result      out  2*WIDTH   last result, registered, held until next EXEC
//  cmp_flags   out  3         {gt,lt,eq} from last CMP, held; cleared by any non-CMP EXEC
//  res_valid   out  1         one-cycle pulse when result/cmp_flags update
//  busy        out  1         high in any state other than IDLE
//  err         out  1         sticky illegal-opcode flag; cleared by the next legal opcode
//  state_o     out  3         current FSM state code, for debug LEDs
// BEHAVIOUR
//  Reset (reset==0 at posedge clk):
//   - All outputs go to 0, and every register R[0..NREG-1] goes to 0.
//   - FSM goes to IDLE and done_q goes to 0.
//   - Reset wins over any simultaneous done edge.
//  Edge detect:
//   - done_q is registered each cycle; step = done & ~done_q.
//   - Holding done high produces exactly one step.
//  Opcodes:
//   - 2-operand ops: ADD 0001, SUB 0011, MUL 0111, CMP 1100, NAND 1000, NOR 1001, XOR 1011.
//   - 1-operand op: LD 1110.
//   - 2-step op: ST 1111 (address first, then value).
//   - Every other opcode is illegal.
//  FSM states: IDLE=0, GET_A=1, GET_B=2, EXEC=3. Transitions happen only on a step, except EXEC.
//   - IDLE + step, legal op: latch opcode, clear err, go to GET_A.
//   - IDLE + step, illegal op: set err, stay in IDLE; result is unchanged.
//   - GET_A + step: latch A = data_in. LD goes to EXEC; all other ops go to GET_B.
//   - GET_B + step: latch B = data_in, go to EXEC.
//   - EXEC lasts one cycle with no step needed: register the outputs, pulse res_valid, return to IDLE.
//   - Latency: res_valid is high in the cycle after the final step.
//   - A step while in EXEC is ignored. op_in is ignored outside IDLE; data_in is ignored in IDLE and EXEC.
//  Arithmetic: A and B are signed, sign-extended to 2*WIDTH before the op.
//   - ADD = A+B, SUB = A-B, MUL = A*B, each a full 2*WIDTH signed result with no overflow.
//   - NAND / NOR / XOR act bitwise on WIDTH bits; result is zero-extended.
//   - CMP is a signed compare: exactly one of gt/lt/eq is set, and result = 0.
//   - After every ADD/SUB/MUL/NAND/NOR/XOR, R[0] <= result[WIDTH-1:0] (accumulator).
//  Register ops:
//   - ST: A[RAW-1:0] is the address, B is the value. R[addr] <= B; result = sign-extended B.
//   - LD: result = sign-extended R[A[RAW-1:0]].
//   - In both, the upper address bits of A are ignored (wrap-around).
//   - A ST to address 0 overwrites the accumulator.
//  Reset mid-operation: any latched opcode and operands are discarded, with no res_valid.
// TESTING (WIDTH=4, NREG=8)
//  - ADD: op 0001, A=0111, B=1000 -> result 8'hFF, res_valid 1 cycle after the 3rd step, R0=4'hF.
//  - SUB/MUL: SUB 3,5 -> 8'hFE. MUL 1000,1000 (-8*-8) -> 8'h40, R0=4'h0.
//  - CMP 0011 vs 1110 -> cmp_flags 3'b100, result 8'h00. Then ADD 1,1 -> cmp_flags cleared to 0.
//  - ST/LD: ST addr 1101 (wraps to 5), value 1010; then LD 0101 -> result 8'hFA.
//  - Illegal op 0010 -> err=1, stays in IDLE, no res_valid. A following legal ADD clears err.
//  - done held high 50 cycles -> one step only.
//  - Reset low while in GET_B -> IDLE, all outputs and registers 0. The next step is treated as an opcode.

Source files
------------

// File: rtl/switch_alu_seq_if.sv
// -----------------------------------------------------------------------------
// switch_alu_seq_if
//   Console-side bundle for the operand-sequencing ALU.
//   master : the switch/button console (drives done, op_in, data_in)
//   slave  : the ALU (drives result, cmp_flags, res_valid, busy, err, state_o)
//   done       step button level, already synchronised and debounced
//   op_in      4-bit opcode, sampled on the step taken in IDLE
//   data_in    WIDTH-bit operand / address / store value
//   result     2*WIDTH-bit registered result, held until the next execute
//   cmp_flags  {gt,lt,eq} from the last CMP
//   res_valid  one-cycle pulse when result/cmp_flags update
//   busy       high whenever the sequencer is not idle
//   err        sticky illegal-opcode flag
//   state_o    FSM state code for the debug LEDs
// -----------------------------------------------------------------------------
interface switch_alu_seq_if #(
    parameter int WIDTH = 4
);
    logic                   done;
    logic [3:0]             op_in;
    logic [WIDTH-1:0]       data_in;
    logic [2*WIDTH-1:0]     result;
    logic [2:0]             cmp_flags;
    logic                   res_valid;
    logic                   busy;
    logic                   err;
    logic [2:0]             state_o;

    modport master (
        output done, op_in, data_in,
        input  result, cmp_flags, res_valid, busy, err, state_o
    );

    modport slave (
        input  done, op_in, data_in,
        output result, cmp_flags, res_valid, busy, err, state_o
    );
endinterface

// File: rtl/switch_alu_seq.sv
// -----------------------------------------------------------------------------
// switch_alu_seq
//   Operand-sequencing signed ALU for the switch/button console. Each rising
//   edge of the done button is one step: the first step takes the opcode, the
//   following steps take A and (except LD) B. One EXEC cycle then updates the
//   registered outputs and pulses res_valid. An NREG-entry register file backs
//   ST/LD, and R[0] doubles as an accumulator for arithmetic/logic results.
//   clk    system clock
//   reset  synchronous active-low reset
//   bus    switch_alu_seq_if.slave (done/op_in/data_in in; results out)
// -----------------------------------------------------------------------------
module switch_alu_seq #(
    parameter int WIDTH = 4,
    parameter int NREG  = 8,
    parameter int RAW   = 3
) (
    input  logic              clk,
    input  logic              reset,
    switch_alu_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GET_A = 2'd1,
        GET_B = 2'd2,
        EXEC  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_CMP  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_ST   = 4'b1111;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_CMP, OP_NAND,
            OP_NOR, OP_XOR, OP_LD, OP_ST: is_legal = 1'b1;
            default:                      is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2*WIDTH-1:0] sext(input logic [WIDTH-1:0] v);
        sext = {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    state_t                 state_q, state_d;
    logic                   done_q;
    logic [3:0]             op_q, op_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic                   err_q, err_d;
    logic [2*WIDTH-1:0]     result_q, result_d;
    logic [2:0]             cmp_q, cmp_d;
    logic                   res_valid_q, res_valid_d;
    logic [WIDTH-1:0]       regs_q [NREG];

    logic                   step;
    logic                   wr_en;
    logic [RAW-1:0]         wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic [RAW-1:0]         reg_addr;
    logic signed [2*WIDTH-1:0] a_ext, b_ext;

    assign step = bus.done & ~done_q;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values computed in the comb processes before this edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            err_q       <= 1'b0;
            result_q    <= '0;
            cmp_q       <= '0;
            res_valid_q <= 1'b0;
            // NOTE: the register file is cleared on reset (LD after reset must
            // read 0), so it is built from flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            done_q      <= bus.done;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            err_q       <= err_d;
            result_q    <= result_d;
            cmp_q       <= cmp_d;
            res_valid_q <= res_valid_d;
            if (wr_en) begin
                regs_q[wr_addr] <= wr_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic and operand capture
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of the block, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (step) begin
                    if (is_legal(bus.op_in)) begin
                        op_d    = bus.op_in;
                        err_d   = 1'b0;
                        state_d = GET_A;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            GET_A: begin
                if (step) begin
                    a_d     = bus.data_in;
                    state_d = (op_q == OP_LD) ? EXEC : GET_B;
                end
            end
            GET_B: begin
                if (step) begin
                    b_d     = bus.data_in;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // A step landing here is dropped; done_q still tracks the
                // button, so the held level cannot produce a later step.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: the result is computed from the operands as they will be
    // latched on the final step, so result and res_valid appear together for
    // the single EXEC cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        result_d    = result_q;
        cmp_d       = cmp_q;
        res_valid_d = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        a_ext       = sext(a_d);
        b_ext       = sext(b_d);
        // Upper address bits of A are dropped: addresses wrap modulo NREG.
        reg_addr    = RAW'(a_d);
        if (state_d == EXEC) begin
            res_valid_d = 1'b1;
            cmp_d       = '0;
            unique case (op_q)
                OP_ADD:  result_d = a_ext + b_ext;
                OP_SUB:  result_d = a_ext - b_ext;
                OP_MUL:  result_d = a_ext * b_ext;
                OP_NAND: result_d = {{WIDTH{1'b0}}, ~(a_d & b_d)};
                OP_NOR:  result_d = {{WIDTH{1'b0}}, ~(a_d | b_d)};
                OP_XOR:  result_d = {{WIDTH{1'b0}}, a_d ^ b_d};
                OP_CMP: begin
                    result_d = '0;
                    cmp_d    = {$signed(a_d) > $signed(b_d),
                                $signed(a_d) < $signed(b_d),
                                a_d == b_d};
                end
                OP_ST: begin
                    result_d = sext(b_d);
                    wr_en    = 1'b1;
                    wr_addr  = reg_addr;
                    wr_data  = b_d;
                end
                OP_LD:   result_d = sext(regs_q[reg_addr]);
                default: result_d = result_q;
            endcase
            // Arithmetic and logic results also land in the accumulator R[0].
            if (op_q != OP_CMP && op_q != OP_ST && op_q != OP_LD) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = result_d[WIDTH-1:0];
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.cmp_flags = cmp_q;
    assign bus.res_valid = res_valid_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state_o   = {1'b0, state_q};

endmodule
